// File: rtl/wb_burst_ram.sv
// wb_burst_ram: single-port Wishbone B3 slave RAM with classic cycles and
// incrementing CTI/BTE bursts (linear, wrap4/8/16) and byte enables.
// One-cycle initial latency, then one beat per clock inside a burst.
module wb_burst_ram #(
    parameter int unsigned MEM_SIZE_BYTES = 32768,
    parameter string       MEMFILE        = ""
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int unsigned AW    = $clog2(MEM_SIZE_BYTES);
    localparam int unsigned WAW   = AW - 2;
    localparam int unsigned DEPTH = MEM_SIZE_BYTES / 4;

    typedef enum logic {StIdle, StBurst} state_t;

    logic [31:0]    mem [DEPTH];
    state_t         state_q;
    logic           ack_q;
    logic           err_q;
    logic           we_q;
    logic [1:0]     bte_q;
    logic [WAW-1:0] addr_q;
    logic [31:0]    dat_q;

    logic           bus_act;
    logic           req;
    logic           cti_ok;
    logic [WAW-1:0] adr_word;
    logic [WAW-1:0] mask;
    logic [WAW-1:0] next_addr;
    logic           wr_en;
    logic           unused_adr;

    assign bus_act  = wb_cyc_i & wb_stb_i;
    // Ack/err are gated by the live strobe so no beat completes without stb.
    assign wb_ack_o = ack_q & bus_act;
    assign wb_err_o = err_q & bus_act;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

    assign req      = bus_act & ~wb_ack_o & ~wb_err_o;
    assign cti_ok   = (wb_cti_i == 3'b000) || (wb_cti_i == 3'b010) || (wb_cti_i == 3'b111);
    assign adr_word = wb_adr_i[AW-1:2];
    assign wr_en    = wb_ack_o & we_q;

    assign unused_adr = ^{wb_adr_i[31:AW], wb_adr_i[1:0]};

    // Burst address advance: bits outside the wrap mask are held.
    always_comb begin
        mask = '1;
        case (bte_q)
            2'b01:   mask = WAW'(3);
            2'b10:   mask = WAW'(7);
            2'b11:   mask = WAW'(15);
            default: mask = '1;
        endcase
        next_addr = (addr_q & ~mask) | ((addr_q + WAW'(1)) & mask);
    end

    // Bus control FSM with registered ack/err and read data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            bte_q   <= 2'b00;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    if (req) begin
                        if (cti_ok) begin
                            addr_q <= adr_word;
                            we_q   <= wb_we_i;
                            bte_q  <= wb_bte_i;
                            dat_q  <= mem[adr_word];
                            ack_q  <= 1'b1;
                            if (wb_cti_i == 3'b010) begin
                                state_q <= StBurst;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StBurst: begin
                    if (bus_act) begin
                        // Prefetch the next beat while the current one completes.
                        addr_q <= next_addr;
                        dat_q  <= mem[next_addr];
                        if (wb_cti_i != 3'b010) begin
                            ack_q   <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    // Byte-lane writes on every acked write beat at the current beat address.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) begin
                    mem[addr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule
